// File: rtl/regfile_pkg.sv
// Shared register-file constants and types, reused by decode and execute.
package regfile_pkg;

  localparam int REG_ADDR_W = 6;
  localparam int REG_DATA_W = 16;
  localparam int REG_COUNT  = 64;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port with write-first bypass.
// Port 2 takes priority over port 1 on a bypass hit.
// Reads of register 0 (when hard-wired) and out-of-range addresses return 0.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = REG_COUNT,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int DATA_W   = REG_DATA_W,
  parameter int ZERO_REG = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] regs [NUM_REGS],
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  input  logic              wr1_enable,
  input  logic [ADDR_W-1:0] wr2_addr,
  input  logic [DATA_W-1:0] wr2_data,
  input  logic              wr2_enable,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(NUM_REGS);

  logic              in_range;
  logic              zero_hit;
  logic [DATA_W-1:0] rd_data_next;
  logic [DATA_W-1:0] rd_data_reg;

  assign in_range = ({1'b0, rd_addr} < ADDR_LIMIT);
  assign zero_hit = (ZERO_REG != 0) && (rd_addr == '0);

  // Select the value the entry will hold after this edge's writes.
  always_comb begin
    rd_data_next = '0;
    if (in_range && !zero_hit) begin
      if (wr2_enable && (wr2_addr == rd_addr)) begin
        rd_data_next = wr2_data;
      end else if (wr1_enable && (wr1_addr == rd_addr)) begin
        rd_data_next = wr1_data;
      end else begin
        rd_data_next = regs[rd_addr];
      end
    end
  end

  // Output flop; cleared immediately by reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_reg <= '0;
    end else begin
      rd_data_reg <= rd_data_next;
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/register_file.sv
// 3-read / 2-write register file with registered, write-first reads.
// Write requests are qualified here (range, zero register, collision) so the
// storage and all read-port bypasses see one consistent view of each edge.
module register_file
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = REG_COUNT,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int DATA_W   = REG_DATA_W,
  parameter int ZERO_REG = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] reg_rd1,
  input  logic [ADDR_W-1:0] reg_rd2,
  input  logic [ADDR_W-1:0] reg_rd3,
  output logic [DATA_W-1:0] reg_rd1_out,
  output logic [DATA_W-1:0] reg_rd2_out,
  output logic [DATA_W-1:0] reg_rd3_out,
  input  logic [ADDR_W-1:0] reg_wr1,
  input  logic [DATA_W-1:0] reg_wr1_data,
  input  logic              reg_wr1_enable,
  input  logic [ADDR_W-1:0] reg_wr2,
  input  logic [DATA_W-1:0] reg_wr2_data,
  input  logic              reg_wr2_enable
);

  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(NUM_REGS);

  logic [DATA_W-1:0] regs_reg [NUM_REGS];
  logic              wr1_ok;
  logic              wr2_ok;
  logic              wr1_enable_eff;
  logic              wr2_enable_eff;
  logic              collision;
  logic [NUM_REGS-1:0] wr1_sel;
  logic [NUM_REGS-1:0] wr2_sel;

  // A write is dropped if out of range or aimed at a hard-wired zero register.
  assign wr1_ok = ({1'b0, reg_wr1} < ADDR_LIMIT) && !((ZERO_REG != 0) && (reg_wr1 == '0));
  assign wr2_ok = ({1'b0, reg_wr2} < ADDR_LIMIT) && !((ZERO_REG != 0) && (reg_wr2 == '0));

  // Same-address writes: port 2 wins, port 1 is discarded for the edge.
  assign collision      = reg_wr1_enable && reg_wr2_enable && (reg_wr1 == reg_wr2);
  assign wr2_enable_eff = reg_wr2_enable && wr2_ok;
  assign wr1_enable_eff = reg_wr1_enable && wr1_ok && !collision;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_sel
      assign wr1_sel[gi] = wr1_enable_eff && (reg_wr1 == ADDR_W'(gi));
      assign wr2_sel[gi] = wr2_enable_eff && (reg_wr2 == ADDR_W'(gi));
    end
  endgenerate

  // Storage update; every entry is flop-based so reset can clear it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr2_sel[i]) begin
          regs_reg[i] <= reg_wr2_data;
        end else if (wr1_sel[i]) begin
          regs_reg[i] <= reg_wr1_data;
        end
      end
    end
  end

  logic [ADDR_W-1:0] rd_addr [3];
  logic [DATA_W-1:0] rd_data [3];

  assign rd_addr[0] = reg_rd1;
  assign rd_addr[1] = reg_rd2;
  assign rd_addr[2] = reg_rd3;

  generate
    for (gi = 0; gi < 3; gi++) begin : g_rd
      regfile_read_port #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .ZERO_REG (ZERO_REG)
      ) u_read_port (
        .clock      (clock),
        .reset_n    (reset_n),
        .rd_addr    (rd_addr[gi]),
        .regs       (regs_reg),
        .wr1_addr   (reg_wr1),
        .wr1_data   (reg_wr1_data),
        .wr1_enable (wr1_enable_eff),
        .wr2_addr   (reg_wr2),
        .wr2_data   (reg_wr2_data),
        .wr2_enable (wr2_enable_eff),
        .rd_data    (rd_data[gi])
      );
    end
  endgenerate

  assign reg_rd1_out = rd_data[0];
  assign reg_rd2_out = rd_data[1];
  assign reg_rd3_out = rd_data[2];

  // Out-of-range accesses only exist when the address space is not full.
  generate
    if (NUM_REGS < (1 << ADDR_W)) begin : g_range_check
      a_wr1_range: assert property (@(posedge clock) disable iff (!reset_n)
        !(reg_wr1_enable && ({1'b0, reg_wr1} >= ADDR_LIMIT)));
      a_wr2_range: assert property (@(posedge clock) disable iff (!reset_n)
        !(reg_wr2_enable && ({1'b0, reg_wr2} >= ADDR_LIMIT)));
      a_rd_range: assert property (@(posedge clock) disable iff (!reset_n)
        ({1'b0, reg_rd1} < ADDR_LIMIT) && ({1'b0, reg_rd2} < ADDR_LIMIT) &&
        ({1'b0, reg_rd3} < ADDR_LIMIT));
    end
  endgenerate

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: vector table plus reset and zero-register sequences.
module tb_register_file;
  import regfile_pkg::*;

  logic      clock = 1'b0;
  logic      reset_n;
  reg_addr_t rd1, rd2, rd3, wr1, wr2;
  reg_data_t wr1_data, wr2_data;
  logic      wr1_en, wr2_en;
  reg_data_t o1, o2, o3;
  reg_data_t z1, z2, z3;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic      we1;
    reg_addr_t a1;
    reg_data_t d1;
    logic      we2;
    reg_addr_t a2;
    reg_data_t d2;
    reg_addr_t r1, r2, r3;
    reg_data_t e1, e2, e3;
  } vec_t;

  vec_t vecs [12];

  always #5 clock = ~clock;

  register_file #(.ZERO_REG(0)) u_dut (
    .clock(clock), .reset_n(reset_n),
    .reg_rd1(rd1), .reg_rd2(rd2), .reg_rd3(rd3),
    .reg_rd1_out(o1), .reg_rd2_out(o2), .reg_rd3_out(o3),
    .reg_wr1(wr1), .reg_wr1_data(wr1_data), .reg_wr1_enable(wr1_en),
    .reg_wr2(wr2), .reg_wr2_data(wr2_data), .reg_wr2_enable(wr2_en)
  );

  register_file #(.ZERO_REG(1)) u_dut_zero (
    .clock(clock), .reset_n(reset_n),
    .reg_rd1(rd1), .reg_rd2(rd2), .reg_rd3(rd3),
    .reg_rd1_out(z1), .reg_rd2_out(z2), .reg_rd3_out(z3),
    .reg_wr1(wr1), .reg_wr1_data(wr1_data), .reg_wr1_enable(wr1_en),
    .reg_wr2(wr2), .reg_wr2_data(wr2_data), .reg_wr2_enable(wr2_en)
  );

  task automatic check(input string name, input reg_data_t act, input reg_data_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we1, input reg_addr_t a1, input reg_data_t d1,
                       input logic we2, input reg_addr_t a2, input reg_data_t d2,
                       input reg_addr_t r1, input reg_addr_t r2, input reg_addr_t r3);
    wr1_en = we1; wr1 = a1; wr1_data = d1;
    wr2_en = we2; wr2 = a2; wr2_data = d2;
    rd1 = r1; rd2 = r2; rd3 = r3;
  endtask

  initial begin
    //           we1   a1     d1        we2   a2     d2        r1     r2     r3     e1        e2        e3
    vecs[0]  = '{1'b1, 6'd10, 16'h1234, 1'b0, 6'd0,  16'h0000, 6'd0,  6'd0,  6'd0,  16'h0000, 16'h0000, 16'h0000};
    vecs[1]  = '{1'b0, 6'd0,  16'h0000, 1'b0, 6'd0,  16'h0000, 6'd10, 6'd0,  6'd0,  16'h1234, 16'h0000, 16'h0000};
    vecs[2]  = '{1'b0, 6'd0,  16'h0000, 1'b0, 6'd0,  16'h0000, 6'd10, 6'd0,  6'd0,  16'h1234, 16'h0000, 16'h0000};
    vecs[3]  = '{1'b1, 6'd7,  16'hA5A5, 1'b0, 6'd0,  16'h0000, 6'd7,  6'd7,  6'd7,  16'hA5A5, 16'hA5A5, 16'hA5A5};
    vecs[4]  = '{1'b1, 6'd3,  16'h1111, 1'b1, 6'd3,  16'h2222, 6'd3,  6'd7,  6'd10, 16'h2222, 16'hA5A5, 16'h1234};
    vecs[5]  = '{1'b0, 6'd0,  16'h0000, 1'b0, 6'd0,  16'h0000, 6'd3,  6'd3,  6'd0,  16'h2222, 16'h2222, 16'h0000};
    vecs[6]  = '{1'b1, 6'd1,  16'h00FF, 1'b1, 6'd2,  16'hFF00, 6'd1,  6'd2,  6'd0,  16'h00FF, 16'hFF00, 16'h0000};
    vecs[7]  = '{1'b0, 6'd0,  16'h0000, 1'b0, 6'd0,  16'h0000, 6'd1,  6'd2,  6'd0,  16'h00FF, 16'hFF00, 16'h0000};
    vecs[8]  = '{1'b0, 6'd4,  16'hDEAD, 1'b1, 6'd5,  16'h5555, 6'd4,  6'd5,  6'd4,  16'h0000, 16'h5555, 16'h0000};
    vecs[9]  = '{1'b1, 6'd63, 16'hCAFE, 1'b1, 6'd0,  16'h0BAD, 6'd63, 6'd0,  6'd62, 16'hCAFE, 16'h0BAD, 16'h0000};
    vecs[10] = '{1'b0, 6'd0,  16'h0000, 1'b0, 6'd0,  16'h0000, 6'd63, 6'd0,  6'd5,  16'hCAFE, 16'h0BAD, 16'h5555};
    vecs[11] = '{1'b1, 6'd10, 16'h7777, 1'b0, 6'd10, 16'h9999, 6'd10, 6'd63, 6'd2,  16'h7777, 16'hCAFE, 16'hFF00};

    reset_n = 1'b0;
    drive(1'b0, 6'd0, 16'h0, 1'b0, 6'd0, 16'h0, 6'd0, 6'd0, 6'd0);
    #1;
    check("reset_rd1", o1, 16'h0000);
    check("reset_rd2", o2, 16'h0000);
    check("reset_rd3", o3, 16'h0000);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Table-driven vectors: one edge each, outputs sampled 1 time unit after the edge.
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      drive(vecs[i].we1, vecs[i].a1, vecs[i].d1, vecs[i].we2, vecs[i].a2, vecs[i].d2,
            vecs[i].r1, vecs[i].r2, vecs[i].r3);
      @(posedge clock);
      #1;
      $display("vec %0d: wr1 %0b R%0d=%h wr2 %0b R%0d=%h rd %0d/%0d/%0d -> %h %h %h",
               i, vecs[i].we1, vecs[i].a1, vecs[i].d1, vecs[i].we2, vecs[i].a2, vecs[i].d2,
               vecs[i].r1, vecs[i].r2, vecs[i].r3, o1, o2, o3);
      check($sformatf("vec%0d_rd1", i), o1, vecs[i].e1);
      check($sformatf("vec%0d_rd2", i), o2, vecs[i].e2);
      check($sformatf("vec%0d_rd3", i), o3, vecs[i].e3);
    end

    // Asynchronous reset mid-cycle clears outputs before any edge.
    @(negedge clock);
    drive(1'b1, 6'd5, 16'hBEEF, 1'b0, 6'd0, 16'h0, 6'd5, 6'd10, 6'd63);
    @(posedge clock);
    #1;
    $display("seq reset: wrote R5=BEEF, rd1 -> %h", o1);
    check("pre_reset_rd1", o1, 16'hBEEF);
    #2;
    reset_n = 1'b0;
    #1;
    $display("seq reset: async assert -> %h %h %h", o1, o2, o3);
    check("async_reset_rd1", o1, 16'h0000);
    check("async_reset_rd2", o2, 16'h0000);
    check("async_reset_rd3", o3, 16'h0000);
    drive(1'b1, 6'd6, 16'h1234, 1'b1, 6'd7, 16'h4321, 6'd5, 6'd10, 6'd63);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    drive(1'b0, 6'd0, 16'h0, 1'b0, 6'd0, 16'h0, 6'd5, 6'd6, 6'd7);
    @(posedge clock);
    #1;
    $display("seq reset: after release rd R5/R6/R7 -> %h %h %h", o1, o2, o3);
    check("post_reset_r5", o1, 16'h0000);
    check("post_reset_r6", o2, 16'h0000);
    check("post_reset_r7", o3, 16'h0000);

    // Zero-register build versus normal build on address 0.
    @(negedge clock);
    drive(1'b1, 6'd0, 16'hFFFF, 1'b0, 6'd0, 16'h0, 6'd0, 6'd0, 6'd0);
    @(posedge clock);
    #1;
    $display("seq zero: write R0=FFFF bypass -> normal %h zero %h", o1, z1);
    check("zero_bypass", z1, 16'h0000);
    check("normal_r0_bypass", o1, 16'hFFFF);
    @(negedge clock);
    drive(1'b0, 6'd0, 16'h0, 1'b0, 6'd0, 16'h0, 6'd0, 6'd0, 6'd0);
    @(posedge clock);
    #1;
    $display("seq zero: read R0 -> normal %h zero %h", o1, z1);
    check("zero_later_read", z1, 16'h0000);
    check("normal_r0_read", o1, 16'hFFFF);
    @(negedge clock);
    drive(1'b1, 6'd0, 16'h1111, 1'b1, 6'd0, 16'h2222, 6'd0, 6'd0, 6'd0);
    @(posedge clock);
    #1;
    $display("seq zero: collision on R0 -> normal %h zero %h", o1, z2);
    check("zero_collision", z2, 16'h0000);
    check("normal_r0_collision", o1, 16'h2222);
    @(negedge clock);
    drive(1'b0, 6'd0, 16'h0, 1'b0, 6'd0, 16'h0, 6'd0, 6'd0, 6'd0);
    @(posedge clock);
    #1;
    $display("seq zero: read R0 after collision -> normal %h zero %h", o3, z3);
    check("zero_after_collision", z3, 16'h0000);
    check("normal_after_collision", o3, 16'h2222);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 64 x 16-bit general register file serving the execution stage.
- Three read ports: both source operands plus the destination, for read-modify-write operations.
- Two write ports: primary result, plus secondary result for future dual-write ops such as load with post-increment.
- Registered read data with write-first bypass; a value written at an edge is visible on read outputs from that same edge.

Parameters:
NUM_REGS, 64, number of architectural registers
ADDR_W, 6, register address width (log2 NUM_REGS)
DATA_W, 16, register data width
ZERO_REG, 0, when 1 register 0 always reads 0 and ignores writes

Ports:
clock  input  1  single clock; all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
reg_rd1  input  ADDR_W  read port 1 address (source 1)
reg_rd2  input  ADDR_W  read port 2 address (source 2)
reg_rd3  input  ADDR_W  read port 3 address (destination)
reg_rd1_out  output  DATA_W  read port 1 data, registered
reg_rd2_out  output  DATA_W  read port 2 data, registered
reg_rd3_out  output  DATA_W  read port 3 data, registered
reg_wr1  input  ADDR_W  write port 1 address
reg_wr1_data  input  DATA_W  write port 1 data
reg_wr1_enable  input  1  write port 1 strobe
reg_wr2  input  ADDR_W  write port 2 address
reg_wr2_data  input  DATA_W  write port 2 data
reg_wr2_enable  input  1  write port 2 strobe

Behaviour:
- Reset, asynchronous on reset_n low:
  - All NUM_REGS entries cleared to 0.
  - reg_rd1_out, reg_rd2_out, reg_rd3_out forced to 0.
  - Held while low. Writes presented during reset are dropped.
  - First edge after deassertion operates normally.
- Write:
  - At a rising edge with reg_wrN_enable=1, entry[reg_wrN] <= reg_wrN_data.
  - Enable low means no change regardless of address or data.
- Write collision: both enables high and reg_wr1 == reg_wr2 -> port 2 wins. Entry takes reg_wr2_data; port 1 is discarded for that edge.
- Read:
  - At each rising edge, reg_rdN_out <= value of entry[reg_rdN] after that edge's writes.
  - Latency: address presented in cycle k, data valid after edge k+1.
  - Outputs hold between edges; no read enable.
- Bypass (write-first):
  - If reg_rdN matches an enabled write address at the same edge, reg_rdN_out takes the write data, not the stale entry.
  - Port-2 priority applies to the bypass too.
  - All three read ports bypass independently. Any number may hit the same address.
- ZERO_REG=1:
  - Writes to address 0 ignored.
  - Reads of address 0 return 0, including on a bypass hit.
  - A collision on address 0 writes nothing.
- Addresses >= NUM_REGS, only possible if NUM_REGS < 2**ADDR_W:
  - Writes ignored, reads return 0.
  - Assertion flags the access in simulation.
- No combinational path from any input to any output; all outputs come from flops.
- Storage is plain flops with no RAM inference requirement, since reset must clear every entry.

Decomposition:
- Shared package regfile_pkg:
  - Constants REG_ADDR_W=6, REG_DATA_W=16, REG_COUNT=64.
  - Typedefs reg_addr_t and reg_data_t, reused by the execution and decode stages.
- Sub-module regfile_read_port, instantiated 3x:
  - Inputs: read address, storage array view, both write requests.
  - Implements bypass priority, zero-register masking and the output flop.
- Write decode and collision resolution stay in the top module.

Test Plan:
- Reset: write 0xBEEF to R5, assert reset_n low mid-cycle -> all reg_rdN_out go 0 immediately, without waiting for a clock edge. After release, reading R5 returns 0x0000.
- Basic write/read: edge 1 writes R10=0x1234 (wr1). Edge 2 presents rd1=10 -> reg_rd1_out=0x1234 after edge 3. Outputs hold while the address is unchanged.
- Bypass: same edge writes R7=0xA5A5 via wr1 with rd1=rd2=rd3=7 -> all three outputs 0xA5A5 after that edge. Prior R7 contents are never visible.
- Collision: wr1 R3=0x1111 and wr2 R3=0x2222 on the same edge, rd1=3 -> reg_rd1_out=0x2222 that edge. Subsequent read of R3 also returns 0x2222.
- Dual independent writes: wr1 R1=0x00FF, wr2 R2=0xFF00 on the same edge. Next edge rd1=1, rd2=2, rd3=0 -> 0x00FF, 0xFF00, and R0's contents (0x0000 after reset).
- ZERO_REG=1 build: write R0=0xFFFF with rd1=0 on the same edge -> reg_rd1_out=0x0000 that edge and on all later reads.
